user_input_ctrl: RTL and testbench

//   Producer side of the data-memory user-input slot. Conditions the board

---
 rtl/pico_io_pkg.sv | 17 +
 rtl/sync_ff.sv | 32 +++
 rtl/user_input_ctrl.sv | 126 ++++++++++++
 tb/tb_user_input_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/pico_io_pkg.sv
// Shared types and defaults for the user-input slot of the data memory.
//   key_state_t          : ENTER-key debounce FSM states
//   DEF_DEBOUNCE_CYCLES  : stable cycles needed to accept a key edge
//   DEF_SYNC_STAGES      : flops per input synchronizer
package pico_io_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRESS_DB,
      HELD,
      RELEASE_DB
   } key_state_t;

   localparam int DEF_DEBOUNCE_CYCLES = 50000;
   localparam int DEF_SYNC_STAGES     = 2;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer with asynchronous active-low reset.
//   Clock   in  1      destination clock
//   nReset  in  1      asynchronous, active-low reset (chain loads RESET_VAL)
//   d       in  WIDTH  asynchronous input
//   q       out WIDTH  synchronized output, STAGES edges behind d
module sync_ff #(
   parameter int               WIDTH     = 1,
   parameter int               STAGES    = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             Clock,
   input  logic             nReset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] chain [STAGES];

   // NOTE: the chain is a handful of flops, not a RAM, so every stage is reset;
   // this keeps the released key level from looking like a press after reset.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         for (int i = 0; i < STAGES; i++) chain[i] <= RESET_VAL;
      end else begin
         chain[0] <= d;
         for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/user_input_ctrl.sv
// Producer side of the data-memory user-input slot. Synchronizes the switches
// and the active-low ENTER key, debounces the key, and captures the switch
// byte once per accepted press.
//   Clock       in  1       system clock, rising edge
//   nReset      in  1       asynchronous, active-low reset
//   SW          in  DATA_W  raw switches
//   nKey        in  1       raw ENTER key, 0 = pressed
//   ack         in  1       consumer read the value; clears new_data/overrun
//   usr_input   out DATA_W  captured switch byte
//   new_data    out 1       sticky: capture since last ack
//   overrun     out 1       sticky: capture while new_data already set
//   key_strobe  out 1       one-cycle pulse on each capture
module user_input_ctrl
   import pico_io_pkg::*;
#(
   parameter int DATA_W          = 8,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES
) (
   input  logic              Clock,
   input  logic              nReset,
   input  logic [DATA_W-1:0] SW,
   input  logic              nKey,
   input  logic              ack,
   output logic [DATA_W-1:0] usr_input,
   output logic              new_data,
   output logic              overrun,
   output logic              key_strobe
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

   logic [DATA_W-1:0] sw_s;
   logic              key_s;
   key_state_t        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              capture;

   sync_ff #(.WIDTH(DATA_W), .STAGES(SYNC_STAGES), .RESET_VAL('0)) u_sw_sync (
      .Clock  (Clock),
      .nReset (nReset),
      .d      (SW),
      .q      (sw_s)
   );

   // Key chain resets to the released level.
   sync_ff #(.WIDTH(1), .STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_key_sync (
      .Clock  (Clock),
      .nReset (nReset),
      .d      (nKey),
      .q      (key_s)
   );

   // NOTE: sequential state uses non-blocking assignments so all flops update
   // together from pre-edge values, independent of statement order.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // NOTE: every output of this block gets a default first, so no path leaves
   // a signal unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!key_s) state_d = PRESS_DB;
         end
         PRESS_DB: begin
            if (key_s) begin
               state_d = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               state_d = HELD;
               capture = 1'b1;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         HELD: begin
            if (key_s) state_d = RELEASE_DB;
         end
         RELEASE_DB: begin
            if (!key_s) begin
               state_d = HELD;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      // Each debounce window starts from zero.
      if (state_d != state_q) cnt_d = '0;
   end

   // Capture has priority over ack; overrun samples new_data before any clear.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         usr_input  <= '0;
         new_data   <= 1'b0;
         overrun    <= 1'b0;
         key_strobe <= 1'b0;
      end else begin
         key_strobe <= capture;
         if (capture) begin
            usr_input <= sw_s;
            new_data  <= 1'b1;
            overrun   <= overrun | new_data;
         end else if (ack) begin
            new_data  <= 1'b0;
            overrun   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_user_input_ctrl.sv
module tb_user_input_ctrl;

   logic       Clock = 1'b0;
   logic       nReset;
   logic [7:0] SW;
   logic       nKey;
   logic       ack;
   logic [7:0] usr_input;
   logic       new_data;
   logic       overrun;
   logic       key_strobe;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [7:0] sw;
      logic       nkey;
      logic       ack;
      logic [7:0] e_usr;
      logic       e_new;
      logic       e_ovr;
      logic       e_stb;
   } vec_t;

   vec_t vecs[$];

   user_input_ctrl #(.DATA_W(8), .DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)) dut (
      .Clock      (Clock),
      .nReset     (nReset),
      .SW         (SW),
      .nKey       (nKey),
      .ack        (ack),
      .usr_input  (usr_input),
      .new_data   (new_data),
      .overrun    (overrun),
      .key_strobe (key_strobe)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic [7:0] e_usr,
                             input logic e_new, input logic e_ovr, input logic e_stb);
      check({tag, " usr_input"},  usr_input,         e_usr);
      check({tag, " new_data"},   {7'd0, new_data},   {7'd0, e_new});
      check({tag, " overrun"},    {7'd0, overrun},    {7'd0, e_ovr});
      check({tag, " key_strobe"}, {7'd0, key_strobe}, {7'd0, e_stb});
   endtask

   // Drive at the falling edge, sample 1 time unit after the next rising edge.
   task automatic step(input logic [7:0] sw, input logic nk, input logic a);
      @(negedge Clock);
      SW   = sw;
      nKey = nk;
      ack  = a;
      @(posedge Clock);
      #1;
   endtask

   function automatic void add(input int n, input logic [7:0] sw, input logic nk,
                               input logic a, input logic [7:0] e_usr,
                               input logic e_new, input logic e_ovr, input logic e_stb);
      vec_t v;
      v.sw = sw; v.nkey = nk; v.ack = a;
      v.e_usr = e_usr; v.e_new = e_new; v.e_ovr = e_ovr; v.e_stb = e_stb;
      for (int i = 0; i < n; i++) vecs.push_back(v);
   endfunction

   initial begin
      // Reset idle after release.
      add(2, 8'hA5, 1'b1, 1'b0, 8'h00, 0, 0, 0);
      // Clean press: capture lands on the 7th edge with the key low.
      add(6, 8'h3C, 1'b0, 1'b0, 8'h00, 0, 0, 0);
      add(1, 8'h3C, 1'b0, 1'b0, 8'h3C, 1, 0, 1);
      // Held key with switches changing: no recapture, no strobe.
      add(3, 8'h55, 1'b0, 1'b0, 8'h3C, 1, 0, 0);
      add(8, 8'h55, 1'b1, 1'b0, 8'h3C, 1, 0, 0);
      // Ack clears new_data.
      add(1, 8'h55, 1'b1, 1'b1, 8'h3C, 0, 0, 0);
      add(1, 8'h55, 1'b1, 1'b0, 8'h3C, 0, 0, 0);
      // Press bounce: low 3, high 1, low 2, high -> no capture.
      add(3, 8'h77, 1'b0, 1'b0, 8'h3C, 0, 0, 0);
      add(1, 8'h77, 1'b1, 1'b0, 8'h3C, 0, 0, 0);
      add(2, 8'h77, 1'b0, 1'b0, 8'h3C, 0, 0, 0);
      add(4, 8'h77, 1'b1, 1'b0, 8'h3C, 0, 0, 0);
      // Second press, no ack (full latency again proves FSM was back in IDLE).
      add(6, 8'h81, 1'b0, 1'b0, 8'h3C, 0, 0, 0);
      add(1, 8'h81, 1'b0, 1'b0, 8'h81, 1, 0, 1);
      add(8, 8'h81, 1'b1, 1'b0, 8'h81, 1, 0, 0);
      // Third press -> overrun.
      add(6, 8'h18, 1'b0, 1'b0, 8'h81, 1, 0, 0);
      add(1, 8'h18, 1'b0, 1'b0, 8'h18, 1, 1, 1);
      add(8, 8'h18, 1'b1, 1'b0, 8'h18, 1, 1, 0);
      // Ack clears both; a second ack with new_data=0 changes nothing.
      add(1, 8'h18, 1'b1, 1'b1, 8'h18, 0, 0, 0);
      add(1, 8'h18, 1'b1, 1'b1, 8'h18, 0, 0, 0);
      // Press to set new_data, then a press whose capture cycle carries ack.
      add(6, 8'h2A, 1'b0, 1'b0, 8'h18, 0, 0, 0);
      add(1, 8'h2A, 1'b0, 1'b0, 8'h2A, 1, 0, 1);
      add(8, 8'h2A, 1'b1, 1'b0, 8'h2A, 1, 0, 0);
      add(6, 8'hB4, 1'b0, 1'b0, 8'h2A, 1, 0, 0);
      add(1, 8'hB4, 1'b0, 1'b1, 8'hB4, 1, 1, 1);
      add(8, 8'hB4, 1'b1, 1'b0, 8'hB4, 1, 1, 0);
      add(1, 8'hB4, 1'b1, 1'b1, 8'hB4, 0, 0, 0);

      nReset = 1'b0;
      SW     = 8'hA5;
      nKey   = 1'b1;
      ack    = 1'b0;
      #1;
      check_outs("reset", 8'h00, 0, 0, 0);
      repeat (2) @(negedge Clock);
      nReset = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].sw, vecs[i].nkey, vecs[i].ack);
         check_outs($sformatf("v%0d", i), vecs[i].e_usr, vecs[i].e_new,
                    vecs[i].e_ovr, vecs[i].e_stb);
      end

      // Capture C3, then a release bounce with new switches must not recapture.
      for (int i = 0; i < 6; i++) step(8'hC3, 1'b0, 1'b0);
      step(8'hC3, 1'b0, 1'b0);
      check_outs("c3 capture", 8'hC3, 1, 0, 1);
      for (int i = 0; i < 2; i++) step(8'hC3, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(8'h99, 1'b1, 1'b0);
         check_outs($sformatf("relb hi%0d", i), 8'hC3, 1, 0, 0);
      end
      for (int i = 0; i < 2; i++) begin
         step(8'h99, 1'b0, 1'b0);
         check_outs($sformatf("relb lo%0d", i), 8'hC3, 1, 0, 0);
      end
      for (int i = 0; i < 10; i++) begin
         step(8'h99, 1'b1, 1'b0);
         check_outs($sformatf("relb rel%0d", i), 8'hC3, 1, 0, 0);
      end

      // Async reset in the middle of a press debounce.
      for (int i = 0; i < 4; i++) step(8'h5A, 1'b0, 1'b0);
      check_outs("pre-reset", 8'hC3, 1, 0, 0);
      @(negedge Clock);
      nReset = 1'b0;
      #1;
      check_outs("async reset", 8'h00, 0, 0, 0);
      @(negedge Clock);
      nReset = 1'b1;
      nKey   = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step(8'h5A, 1'b1, 1'b0);
         check_outs($sformatf("post-reset%0d", i), 8'h00, 0, 0, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
